// File: rtl/conv_fmap_relay_if.sv
// conv_fmap_relay_if: upstream result stream plus downstream addressed byte-write bus.
// The slave modport is the relay's view; master is the environment's view.
interface conv_fmap_relay_if #(
    parameter int AW = 5
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data_in;
    logic          out_data_we;
    logic [AW-1:0] out_data_addr;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_data_in, out_data_we, out_data_addr
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data_in, out_data_we, out_data_addr
    );
endinterface

// File: rtl/conv_fmap_relay.sv
// conv_fmap_relay: turns a conv result stream into addressed writes of the next layer's input buffer.
// Zero-border insertion is enabled by defining CONV_FMAP_RELAY_PAD_EN.
module conv_fmap_relay #(
    parameter int CHANNELS   = 128,
    parameter int OUT_WIDTH  = 28,
    parameter int OUT_HEIGHT = 28,
    parameter int PAD        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic done,
    output logic busy,
    output logic overflow,
    conv_fmap_relay_if.slave bus
);
`ifdef CONV_FMAP_RELAY_PAD_EN
    localparam int P = PAD;
`else
    localparam int P = PAD * 0;
`endif
    localparam int PW = OUT_WIDTH + 2 * P;
    localparam int PH = OUT_HEIGHT + 2 * P;
    localparam int N  = CHANNELS * PH * PW;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(PW + 1);
    localparam int YW = $clog2(PH + 1);
    localparam int LW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] pos_q, pos_d;
    logic [LW:0]   cnt_q, cnt_d;
    logic [LW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          ovf_q, ovf_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    dat_q, dat_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          border, push, pop, issue, run, fin, clr, x_wrap;

`ifdef CONV_FMAP_RELAY_PAD_EN
    assign border = x_q < XW'(P) || x_q >= XW'(P + OUT_WIDTH) ||
                    y_q < YW'(P) || y_q >= YW'(P + OUT_HEIGHT);
`else
    assign border = 1'b0;
`endif

    assign bus.in_ready      = state_q == RUN && cnt_q != (LW+1)'(FIFO_DEPTH);
    assign bus.out_data_we   = we_q;
    assign bus.out_data_addr = addr_q;
    assign bus.out_data_in   = dat_q;
    assign done              = state_q == DONE;
    assign busy              = state_q != IDLE;
    assign overflow          = ovf_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pos_d   = pos_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        ovf_d   = ovf_q | (bus.in_valid & ~bus.in_ready);
        we_d    = 1'b0;
        addr_d  = addr_q;
        dat_d   = dat_q;
        clr     = state_q == IDLE && start;
        // Once the final write sits on the outputs, stop issuing and let DONE follow one cycle later.
        fin     = we_q && addr_q == AW'(N - 1);
        run     = state_q == RUN && !fin;
        push    = bus.in_valid && bus.in_ready;
        issue   = run && (border || cnt_q != '0);
        pop     = issue && !border;
        x_wrap  = x_q == XW'(PW - 1);
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        cnt_d   = cnt_q + (LW+1)'(push) - (LW+1)'(pop);
        if (issue) begin
            we_d   = 1'b1;
            addr_d = pos_q;
            dat_d  = border ? 8'd0 : mem[rp_q];
            pos_d  = pos_q + 1'b1;
            x_d    = x_wrap ? '0 : x_q + 1'b1;
            y_d    = x_wrap ? (y_q == YW'(PH - 1) ? '0 : y_q + 1'b1) : y_q;
        end
        if (state_q == RUN && fin) state_d = DONE;
        if (state_q == DONE) state_d = IDLE;
        if (clr) begin
            state_d = RUN;
            x_d     = '0;
            y_d     = '0;
            pos_d   = '0;
            cnt_d   = '0;
            wp_d    = '0;
            rp_d    = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp_q] <= bus.in_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end
endmodule

// File: tb/tb_conv_fmap_relay.sv
// tb_conv_fmap_relay: table-driven frames plus hand-written overflow/reset sequences,
// checked against an address-to-sample model of the padded feature map.
module tb_conv_fmap_relay;
    localparam int C = 2, W = 2, H = 2, FD = 2;
`ifdef CONV_FMAP_RELAY_PAD_EN
    localparam int P = 1;
    localparam bit EXP_BURST_OVF = 1'b1;
`else
    localparam int P = 0;
    localparam bit EXP_BURST_OVF = 1'b0;
`endif
    localparam int PW = W + 2 * P, PH = H + 2 * P;
    localparam int NW = C * PW * PH, NS = C * W * H;
    localparam int AW = $clog2(NW);
    localparam int RST_AT = NW > 10 ? 10 : NW / 2;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic done, busy, overflow;
    int checks = 0, errors = 0;

    conv_fmap_relay_if #(.AW(AW)) bus ();

    conv_fmap_relay #(
        .CHANNELS(C), .OUT_WIDTH(W), .OUT_HEIGHT(H), .PAD(1), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .done(done), .busy(busy),
        .overflow(overflow), .bus(bus)
    );

    always #5 clk = ~clk;

    int wa[$], wd[$], wc[$];
    int cyc = 0, done_n = 0, done_cyc = 0, stall_n = 0;
    logic [7:0] samp [NS];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.out_data_we) begin
            wa.push_back(int'(bus.out_data_addr));
            wd.push_back(int'(bus.out_data_in));
            wc.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && !done && !bus.in_ready) stall_n++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_border(input int a);
        int r = a % (PH * PW);
        int y = r / PW, x = r % PW;
        return x < P || x >= P + W || y < P || y >= P + H;
    endfunction

    function automatic int exp_data(input int a);
        int c = a / (PH * PW), r = a % (PH * PW);
        int y = r / PW, x = r % PW;
        if (is_border(a)) return 0;
        return int'(samp[c * H * W + (y - P) * W + (x - P)]);
    endfunction

    task automatic clear_mon();
        @(posedge clk);
        wa.delete(); wd.delete(); wc.delete();
        done_n = 0; stall_n = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed_until_done(input string nm);
        int t = 0;
        while (done_n == 0 && t < 400) begin
            bus.in_valid = bus.in_ready;
            bus.in_data  = 8'($urandom);
            @(negedge clk); t++;
        end
        bus.in_valid = 1'b0;
        chk({nm, "_done_seen"}, done_n > 0, 1);
    endtask

    task automatic run_frame(input string nm, input int gap, input bit rnd, input bit exp_stall);
        int i = 0, w = 0, t = 0, viol = 0, n;
        clear_mon();
        for (int k = 0; k < NS; k++) samp[k] = rnd ? 8'($urandom_range(1, 255)) : 8'(k + 1);
        pulse_start();
        chk({nm, "_busy"}, busy, 1);
        while (i < NS && t < 2000) begin
            if (w > 0) begin
                bus.in_valid = 1'b0;
                w--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = samp[i];
                if (bus.in_ready) begin
                    i++;
                    w = gap < 0 ? int'($urandom_range(3)) : gap;
                end
            end
            @(negedge clk); t++;
        end
        bus.in_valid = 1'b0;
        chk({nm, "_all_accepted"}, i, NS);
        t = 0;
        while (done_n == 0 && t < 500) begin
            @(negedge clk); t++;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_writes"}, wa.size(), NW);
        n = wa.size() < NW ? wa.size() : NW;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_addr%0d", nm, k), wa[k], k);
            chk($sformatf("%s_data%0d", nm, k), wd[k], exp_data(k));
            if (k > 0 && wc[k] != wc[k-1] + 1 && is_border(wa[k])) viol++;
        end
        chk({nm, "_border_gaps"}, viol, 0);
        chk({nm, "_done_pulses"}, done_n, 1);
        if (n > 0) chk({nm, "_done_timing"}, done_cyc, wc[n-1] + 1);
        chk({nm, "_overflow"}, overflow, 0);
        chk({nm, "_idle_after"}, busy, 0);
        if (exp_stall) chk({nm, "_ready_dropped"}, stall_n > 0, 1);
    endtask

    typedef struct {
        string nm;
        int    gap;
        bit    rnd;
        bit    exp_stall;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int t;
        vecs[0] = '{"basic",      0,  1'b0, P > 0};
        vecs[1] = '{"sparse",     10, 1'b0, 1'b0};
        vecs[2] = '{"rand_gap",   -1, 1'b1, 1'b0};
        vecs[3] = '{"rand_b2b",   0,  1'b1, P > 0};
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_we", bus.out_data_we, 0);
        chk("rst_addr", bus.out_data_addr, 0);
        chk("rst_data", bus.out_data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_ovf", overflow, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) run_frame(vecs[v].nm, vecs[v].gap, vecs[v].rnd, vecs[v].exp_stall);

        // Burst ignoring in_ready right after start.
        clear_mon();
        pulse_start();
        for (int k = 0; k < NS; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k + 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("burst_ovf", overflow, EXP_BURST_OVF);
        feed_until_done("burst");
        repeat (2) @(negedge clk);
        chk("burst_ovf_sticky", overflow, EXP_BURST_OVF);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("idle_drop_ovf", overflow, 1);
        repeat (3) @(negedge clk);
        chk("idle_drop_sticky", overflow, 1);
        clear_mon();
        pulse_start();
        chk("start_clears_ovf", overflow, 0);
        feed_until_done("after_clear");
        repeat (2) @(negedge clk);

        // Reset partway through a frame.
        clear_mon();
        pulse_start();
        t = 0;
        while (wa.size() < RST_AT && t < 500) begin
            bus.in_valid = bus.in_ready;
            bus.in_data  = 8'($urandom);
            @(negedge clk); t++;
        end
        bus.in_valid = 1'b0;
        chk("mid_writes_reached", wa.size() >= RST_AT, 1);
        chk("mid_busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_we", bus.out_data_we, 0);
        chk("mid_rst_addr", bus.out_data_addr, 0);
        chk("mid_rst_data", bus.out_data_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_frame("post_reset", 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_fmap_relay.md
# conv_fmap_relay

Output-side relay for the quantized conv layers. It accepts the 8-bit result stream (`conv_valid`/`conv_result` style) from one layer and converts it into addressed byte writes (`*_data_we`/`*_data_addr`/`*_data_in` style) into the next layer's input buffer. It inserts the zero-padding border on the fly, so the next layer's buffer is filled without host intervention.

## Interface
Parameters:
- `CHANNELS`, 128, number of feature-map channels in the stream.
- `OUT_WIDTH`, 28, unpadded columns per channel.
- `OUT_HEIGHT`, 28, unpadded rows per channel.
- `PAD`, 1, zero-border width on each side; ignored without the macro.
- `FIFO_DEPTH`, 4, input skid FIFO depth (power of two, ≥2).
- Derived: `PW = OUT_WIDTH+2*PAD`, `PH = OUT_HEIGHT+2*PAD`, `AW = $clog2(CHANNELS*PH*PW)`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse that begins one frame; honoured only in IDLE.
- `done`  out  1  one-cycle pulse after the last write of a frame.
- `busy`  out  1  high in RUN and DONE.
- `in_data`  in  8  result sample from the upstream layer.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  FIFO not full and state is RUN.
- `out_data_in`  out  8  write data to the downstream input buffer.
- `out_data_we`  out  1  write strobe.
- `out_data_addr`  out  AW  write address.
- `overflow`  out  1  sticky flag, set when `in_valid && !in_ready`.

Reset value of every output is 0.

## Operation
- Sample order is channel-major, then row, then column, matching the conv output order. Write address order is the same, over the padded space.
- **States:**
  - IDLE → RUN on `start`. At the same time, clear counters, FIFO and `overflow`.
  - RUN → DONE after the write of address `CHANNELS*PH*PW-1` is issued.
  - DONE → IDLE unconditionally. `done` is high for exactly that one cycle.
- **RUN, each cycle:**
  - Border position (`x<PAD`, `x>=PAD+OUT_WIDTH`, `y<PAD` or `y>=PAD+OUT_HEIGHT`): write 0 and advance, without popping the FIFO.
  - Interior position with FIFO non-empty: pop, write the sample, advance.
  - Interior position with FIFO empty: `out_data_we=0`, hold the position.
- **Counters:**
  - x wraps at `PW-1` to 0 and increments y.
  - y wraps at `PH-1` and increments the channel.
  - The linear address is a separate counter that increments on each write. No multiplier is used.
- **Input handling:**
  - `in_valid` in IDLE or DONE is dropped and sets `overflow`.
  - A push when full is also dropped and sets `overflow`.
  - Simultaneous push and pop on a full FIFO is still a drop, because `in_ready` is computed from the registered full flag.
- `start` during RUN or DONE is ignored.
- Samples beyond `CHANNELS*OUT_HEIGHT*OUT_WIDTH` in a frame are never popped. They are discarded at the next `start`.

## Timing
- `out_data_we`, `out_data_addr` and `out_data_in` are registered.
- Latency: a sample accepted at edge N into an empty FIFO, at an interior position, appears on the write outputs after edge N+1.
- Border writes issue back-to-back, one per cycle. A full padded frame takes at least `CHANNELS*PH*PW` cycles.
- `done` rises on the edge after the final write's edge.
- `rstn` low mid-frame aborts immediately: FIFO is emptied, all outputs go to 0, state returns to IDLE. No partial-frame recovery.

## Configuration
- `CONV_FMAP_RELAY_PAD_EN` defined: padding is inserted as above, giving `CHANNELS*PH*PW` writes per frame.
- Macro undefined:
  - No border positions exist; every position is interior.
  - The address space is `CHANNELS*OUT_HEIGHT*OUT_WIDTH`, so `AW` shrinks accordingly.
  - `PAD` is ignored, and writes equal samples one-to-one.

## Test plan
Parameters for all scenarios unless stated: `CHANNELS=2`, `OUT_WIDTH=OUT_HEIGHT=2`, `PAD=1`, macro defined.
1. **Basic frame:** `start`, then samples 1..8 one per cycle (honouring `in_ready`) → exactly 32 writes at addresses 0..31 ascending. Addresses 5,6,9,10,21,22,25,26 carry 1..8; all others carry 0. `done` pulses once, the cycle after address 31; `overflow=0`.
2. **Back-pressure:** `FIFO_DEPTH=2`, `in_valid` held high with data gated by `in_ready` → `in_ready` drops during border runs. Data and addresses match scenario 1 and `overflow` stays 0.
3. **Overflow:** 8 samples driven back-to-back ignoring `in_ready` while the relay is still issuing the leading border writes → `overflow=1` and stays set. The next `start` clears it to 0.
4. **Sparse input:** samples spaced 10 cycles apart → `out_data_we` has gaps only at interior positions. Addresses stay strictly increasing with no repeats, and `done` pulses once.
5. **Reset mid-run:** `rstn` pulled low after 10 writes → all outputs are 0 immediately. A new `start` plus 8 samples reproduces scenario 1 from address 0.
6. **Macro undefined:** `start` plus samples 1..8 → 8 writes at addresses 0..7 with data 1..8, then `done`.
